framebuffer_write_arbiter: RTL
==============================

// Module: framebuffer_write_arbiter
// PURPOSE
//   Shares the single framebuffer write port among NUM_REQ pixel writers (draw engine, host, overlay).
//   Round-robin arbitration, one beat per cycle, with a built-in clear sequencer that fills the whole frame with a colour.
//   Sits between the pixel producers and the framebuffer write port; all logic is on the write clock.
// PARAMETERS
//   FRAME_WIDTH     640  frame width in pixels before scaling
//   FRAME_HEIGHT    480  frame height in pixels before scaling
//   SCALING_FACTOR  1    divisor; NUM_PIXELS = FRAME_WIDTH/SCALING_FACTOR*FRAME_HEIGHT/SCALING_FACTOR
//   ADDR_WIDTH      19   framebuffer address width
//   DATA_WIDTH      8    pixel width
//   NUM_REQ         3    number of requesters, 2..8
// PORTS
//   clk_wr       in   1                    write-domain clock
//   rst          in   1                    synchronous reset, active high
//   req_valid    in   NUM_REQ              per-requester write request
//   req_addr     in   NUM_REQ*ADDR_WIDTH   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data     in   NUM_REQ*DATA_WIDTH   packed pixel data, same packing
//   req_ready    out  NUM_REQ              one-hot accept, combinational from valid/pointer/state
//   clr_start    in   1                    pulse: start frame clear
//   clr_colour   in   DATA_WIDTH           fill value, sampled on clr_start
//   clr_busy     out  1                    clear in progress
//   err_oob      out  1                    one-cycle pulse: accepted request had addr >= NUM_PIXELS
//   en_wr        out  1                    framebuffer write enable (registered)
//   wrea         out  1                    framebuffer write strobe (registered, equals en_wr)
//   addr_wr      out  ADDR_WIDTH           framebuffer write address (registered)
//   din          out  DATA_WIDTH           framebuffer write data (registered)
// BEHAVIOUR
//   Reset: state IDLE, rr pointer 0, clr_busy 0, err_oob 0, en_wr/wrea 0, addr_wr 0, din 0, req_ready 0.
//   States: IDLE (arbitrate requesters) and CLEAR (sequence fill).
//   IDLE: grant = first i with req_valid[i], searching from pointer upward, wrapping; req_ready[grant]=1, all others 0.
//     Accept = valid & ready. Next cycle: en_wr=wrea=1, addr_wr/din = granted addr/data. Latency 1 cycle.
//     After an accept, pointer <= grant+1, wrapping NUM_REQ-1 -> 0; with no accept the pointer holds.
//     With no accept: en_wr=wrea=0; addr_wr/din hold their last values.
//     Out-of-range addr (>= NUM_PIXELS): still accepted and pointer advances; no write (en_wr=0); err_oob=1 for one cycle.
//   clr_start in IDLE: all req_ready forced 0 that cycle (clear beats a simultaneous request), colour latched, counter <= 0, -> CLEAR.
//   CLEAR: clr_busy=1; each cycle write counter to addr_wr, colour to din, en_wr=wrea=1.
//     counter++ each cycle; after the write of NUM_PIXELS-1, -> IDLE.
//     clr_busy drops on the cycle after the last write is issued.
//     req_ready=0 throughout CLEAR; requesters must hold valid/addr/data until accepted.
//   clr_start during CLEAR: restart at addr 0 with the newly sampled colour; the remaining old addresses are not written.
//   Clear duration: first write in cycle N+1 after the clr_start at cycle N; NUM_PIXELS consecutive write cycles, no gaps.
//   rst at any time: immediate return to reset values next edge; a clear in progress is abandoned (partial frame).
//   Counter is ADDR_WIDTH bits; NUM_PIXELS must be <= 2**ADDR_WIDTH (compile-time check).
// TESTING
//   Reset: rst high 2 cycles -> all outputs 0, clr_busy 0.
//   RR fairness: NUM_REQ=3, all valid held 9 cycles -> grants 0,1,2,0,1,2,0,1,2; each write appears 1 cycle after its accept.
//   Sparse: only req 2 valid, addr=100, data=0x5A -> ready[2] same cycle; next cycle en_wr=1, addr_wr=100, din=0x5A.
//   Clear: clr_start, colour 0x33, with FRAME 8x4 -> 32 consecutive writes addr 0..31 din=0x33; clr_busy high 32 cycles; no req_ready during.
//   Clear restart + collision: clr_start at clear addr 10 with colour 0x77 -> next write addr 0 din 0x77; a valid asserted together with the initial clr_start is accepted only after the clear ends.
//   OOB + mid-op reset: addr=NUM_PIXELS -> ready 1, err_oob pulse, no en_wr; rst during clear -> en_wr 0 and clr_busy 0 next cycle.

Source files
------------

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port, with a built-in frame-clear sequencer.
// States: IDLE = arbitrate pixel writers, CLEAR = fill every pixel with the latched colour.
module framebuffer_write_arbiter #(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int SCALING_FACTOR = 1,
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQ        = 3
) (
    input  logic                          clk_wr,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          clr_start,
    input  logic [DATA_WIDTH-1:0]         clr_colour,
    output logic                          clr_busy,
    output logic                          err_oob,
    output logic                          en_wr,
    output logic                          wrea,
    output logic [ADDR_WIDTH-1:0]         addr_wr,
    output logic [DATA_WIDTH-1:0]         din
);

    localparam int NUM_PIXELS = (FRAME_WIDTH / SCALING_FACTOR) * (FRAME_HEIGHT / SCALING_FACTOR);
    localparam int PTR_W      = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH:0]   NUM_PIX_EXT = (ADDR_WIDTH+1)'(NUM_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX    = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [PTR_W-1:0]      LAST_REQ    = PTR_W'(NUM_REQ - 1);

    if (64'(NUM_PIXELS) > (64'd1 << ADDR_WIDTH)) begin : g_chk_pixels
        $error("NUM_PIXELS does not fit in ADDR_WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_req
        $error("NUM_REQ must be 2..8");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  colour_q, colour_d;
    logic                   en_q, en_d;
    logic                   err_q, err_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;

    logic                   found;
    logic [PTR_W-1:0]       grant_idx;
    int                     idx;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  grant_addr;
    logic [DATA_WIDTH-1:0]  grant_data;

    // Search upward from the pointer, wrapping, for the first valid requester.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    assign grant_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign grant_data = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // A clear request wins over any simultaneous pixel write.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && !clr_start && found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |req_ready;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        en_d     = 1'b0;
        err_d    = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    colour_d = clr_colour;
                    cnt_d    = '0;
                    state_d  = CLEAR;
                end else if (accept) begin
                    ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + PTR_W'(1);
                    if ({1'b0, grant_addr} >= NUM_PIX_EXT) begin
                        err_d = 1'b1;
                    end else begin
                        en_d   = 1'b1;
                        addr_d = grant_addr;
                        din_d  = grant_data;
                    end
                end
            end
            CLEAR: begin
                if (clr_start) begin
                    colour_d = clr_colour;
                    cnt_d    = '0;
                end else begin
                    en_d   = 1'b1;
                    addr_d = cnt_q;
                    din_d  = colour_q;
                    cnt_d  = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_PIX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            colour_q <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
            en_q     <= en_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign err_oob  = err_q;
    assign en_wr    = en_q;
    assign wrea     = en_q;
    assign addr_wr  = addr_q;
    assign din      = din_q;

endmodule
